// File: rtl/fir_pe_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed FIR scheduler.
// Holds the state encodings, datapath widths and default parameter values.
package fir_pe_ctrl_pkg;

  localparam int SAMPLE_W     = 4;
  localparam int COEF_W       = 8;
  localparam int DEF_NUM_TAPS = 8;
  localparam int DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [COEF_W-1:0]   coef_t;

  // The wait timer only ever holds TIMEOUT-1 down to 0.
  function automatic int tmr_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/fir_pe_tapbank.sv
// Coefficient register file plus sample delay line, both read at the tap index.
// Write and shift may happen in the same cycle.
module fir_pe_tapbank
  import fir_pe_ctrl_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int AW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  coef_t         wr_data,
  input  logic          shift_en,
  input  sample_t       shift_data,
  input  logic [AW-1:0] rd_addr,
  output coef_t         rd_coef,
  output sample_t       rd_sample
);

  coef_t   coef_q [NUM_TAPS];
  coef_t   coef_d [NUM_TAPS];
  sample_t x_q    [NUM_TAPS];
  sample_t x_d    [NUM_TAPS];

  always_comb begin
    coef_d = coef_q;
    x_d    = x_q;
    if (wr_en) begin
      coef_d[wr_addr] = wr_data;
    end
    if (shift_en) begin
      x_d[0] = shift_data;
      for (int i = 1; i < NUM_TAPS; i++) begin
        x_d[i] = x_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_q[i] <= '0;
        x_q[i]    <= '0;
      end
    end else begin
      coef_q <= coef_d;
      x_q    <= x_d;
    end
  end

  assign rd_coef   = coef_q[rd_addr];
  assign rd_sample = x_q[rd_addr];

endmodule

// File: rtl/fir_pe_ctrl.sv
// Schedules one FIR sample over a single shared PE, one tap per ISSUE/WAIT pair,
// chaining the partial sum through the PE and presenting the result on a valid/ready port.
//
// state | meaning
// IDLE  | ready for a sample; coefficient writes accepted
// ISSUE | one-cycle PE start for tap k
// WAIT  | operands held, waiting for pe_vld or timer expiry
// DONE  | result held on out_data until out_ready
module fir_pe_ctrl
  import fir_pe_ctrl_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int AW       = 3,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [COEF_W-1:0]   cfg_data,
  output logic                cfg_err,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  input  logic                out_ready,
  output logic [COEF_W-1:0]   pe_cin,
  output logic [SAMPLE_W-1:0] pe_xin,
  output logic [SAMPLE_W-1:0] pe_yin,
  output logic                pe_rdy,
  input  logic [SAMPLE_W-1:0] pe_yout,
  input  logic                pe_vld,
  output logic                pe_timeout
);

  localparam int            TW     = tmr_width(TIMEOUT);
  localparam logic [TW-1:0] TMR_LD = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] K_LAST = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   NT_EXT = (AW + 1)'(NUM_TAPS);

  state_e        state_q,      state_d;
  logic [AW-1:0] k_q,          k_d;
  sample_t       partial_q,    partial_d;
  logic [TW-1:0] tmr_q,        tmr_d;
  logic          in_ready_q,   in_ready_d;
  logic          pe_rdy_q,     pe_rdy_d;
  logic          out_valid_q,  out_valid_d;
  logic          cfg_err_q,    cfg_err_d;
  logic          pe_timeout_q, pe_timeout_d;

  logic    accept;
  logic    wr_ok;
  coef_t   rd_coef;
  sample_t rd_sample;

  assign accept = (state_q == ST_IDLE) && in_ready_q && in_valid;
  assign wr_ok  = cfg_we && (state_q == ST_IDLE) && ({1'b0, cfg_addr} < NT_EXT);

  fir_pe_tapbank #(
    .NUM_TAPS (NUM_TAPS),
    .AW       (AW)
  ) u_tapbank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_ok),
    .wr_addr    (cfg_addr),
    .wr_data    (cfg_data),
    .shift_en   (accept),
    .shift_data (in_data),
    .rd_addr    (k_q),
    .rd_coef    (rd_coef),
    .rd_sample  (rd_sample)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    partial_d    = partial_q;
    tmr_d        = tmr_q;
    pe_timeout_d = 1'b0;
    cfg_err_d    = cfg_we && !wr_ok;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          k_d       = '0;
          partial_d = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_d   = TMR_LD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pe_vld) begin
          partial_d = pe_yout;
          if (k_q == K_LAST) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (tmr_q == '0) begin
          // Abort drops the sample but leaves the delay-line shift in place.
          pe_timeout_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    pe_rdy_d    = (state_d == ST_ISSUE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      partial_q    <= '0;
      tmr_q        <= '0;
      in_ready_q   <= 1'b0;
      pe_rdy_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      pe_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      partial_q    <= partial_d;
      tmr_q        <= tmr_d;
      in_ready_q   <= in_ready_d;
      pe_rdy_q     <= pe_rdy_d;
      out_valid_q  <= out_valid_d;
      cfg_err_q    <= cfg_err_d;
      pe_timeout_q <= pe_timeout_d;
    end
  end

  // Operands come straight from registers, so they stay put for the whole WAIT.
  assign pe_cin     = rd_coef;
  assign pe_xin     = rd_sample;
  assign pe_yin     = partial_q;
  assign pe_rdy     = pe_rdy_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? partial_q : '0;
  assign cfg_err    = cfg_err_q;
  assign pe_timeout = pe_timeout_q;

endmodule

// File: tb/tb_fir_pe_ctrl.sv
// Bench for fir_pe_ctrl with NUM_TAPS=4: a behavioural PE, a sum-of-products
// reference model, directed scenarios and a randomized run.
module tb_fir_pe_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic [3:0]    in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [3:0]    out_data;
  logic          out_ready = 1'b0;
  logic [7:0]    pe_cin;
  logic [3:0]    pe_xin;
  logic [3:0]    pe_yin;
  logic          pe_rdy;
  logic [3:0]    pe_yout = '0;
  logic          pe_vld = 1'b0;
  logic          pe_timeout;

  int n_pass  = 0;
  int n_total = 0;

  // PE model controls
  int pe_extra = 0;
  bit pe_mute  = 1'b0;
  bit pe_noise = 1'b0;
  int pend     = 0;

  // Reference model: coefficient bank and sample history, newest first
  logic [7:0] m_coef [N];
  logic [3:0] m_hist [N];

  fir_pe_ctrl #(.NUM_TAPS(N), .AW(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .pe_cin     (pe_cin),
    .pe_xin     (pe_xin),
    .pe_yin     (pe_yin),
    .pe_rdy     (pe_rdy),
    .pe_yout    (pe_yout),
    .pe_vld     (pe_vld),
    .pe_timeout (pe_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // PE: Yout=(Yin+Cin[3:0]*Xin) mod 16, Vld 1+pe_extra cycles after Rdy
  always @(negedge clk) begin
    pe_vld = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) pe_vld = !pe_mute;
    end else if (pe_noise) begin
      pe_vld = 1'($urandom_range(0, 1));
    end
    if (pe_rdy) begin
      pend    = 1 + pe_extra;
      pe_yout = 4'((int'(pe_yin) + int'(pe_cin[3:0]) * int'(pe_xin)) % 16);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] m_partial(input int upto);
    int s = 0;
    for (int j = 0; j < upto; j++) s += int'(m_coef[j][3:0]) * int'(m_hist[j]);
    return 4'(s % 16);
  endfunction

  function automatic void m_clear();
    for (int j = 0; j < N; j++) begin
      m_coef[j] = '0;
      m_hist[j] = '0;
    end
  endfunction

  function automatic void m_shift(input logic [3:0] d);
    for (int j = N - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_clear();
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    m_coef[a] = d;
  endtask

  task automatic run_sample(input logic [3:0] din, input int extra, input bit cw,
                            input logic [AW-1:0] cw_addr, input logic [7:0] cw_data,
                            input int hold, input bit inj_cfg);
    int guard = 0;
    int cyc;
    int tap = 0;
    bit op_ok = 1'b1;
    bit busy_ok = 1'b1;
    bit stable_ok = 1'b1;
    logic [3:0] exp_y;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 1);
    pe_extra = extra;
    in_valid = 1'b1; in_data = din;
    if (cw) begin
      cfg_we = 1'b1; cfg_addr = cw_addr; cfg_data = cw_data;
    end
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    if (cw) m_coef[cw_addr] = cw_data;
    m_shift(din);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_ok = 1'b0;
      if (pe_rdy) begin
        if (tap >= N || pe_cin !== m_coef[tap] || pe_xin !== m_hist[tap] ||
            pe_yin !== m_partial(tap)) op_ok = 1'b0;
        tap++;
      end
      if (inj_cfg) begin
        if (cyc == 2) begin
          cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'hA5;
        end else begin
          cfg_we = 1'b0;
        end
        if (cyc == 3) chk("cfg_err_pulse", 32'(cfg_err), 1);
        if (cyc == 4) chk("cfg_err_one_cycle", 32'(cfg_err), 0);
      end
      tick();
      cyc++;
    end
    cfg_we = 1'b0;
    chk("out_latency", 32'(cyc), 32'(2 * N + 1 + N * extra));
    chk("issue_operands", 32'(op_ok && tap == N), 1);
    chk("in_ready_low_busy", 32'(busy_ok), 1);
    exp_y = m_partial(N);
    chk("out_data", 32'(out_data), 32'(exp_y));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 4'($urandom);
      if (!out_valid || out_data !== exp_y || in_ready) stable_ok = 1'b0;
      tick();
    end
    if (hold > 0) chk("hold_stable", 32'(stable_ok && out_valid && !in_ready), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_handshake", 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  initial begin
    int cyc;
    int to_cnt;
    int first_to;
    bit saw_ov;
    m_clear();

    // Reset state
    tick();
    chk("in_ready_in_reset", 32'(in_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_outputs", 32'({out_valid, out_data, pe_rdy, pe_cin, pe_xin, pe_yin, cfg_err, pe_timeout}), 0);

    // All coefficients zero
    run_sample(4'd9, 0, 1'b0, '0, '0, 0, 1'b0);
    chk("zero_coef_out", 32'(m_partial(N)), 0);

    // Coefficients all 1, samples 1,2,3 -> 1,3,6
    do_reset();
    for (int a = 0; a < N; a++) cfg_write(AW'(a), 8'd1);
    chk("cfg_err_legal_write", 32'(cfg_err), 0);
    run_sample(4'd1, 0, 1'b0, '0, '0, 0, 1'b0);
    run_sample(4'd2, 0, 1'b0, '0, '0, 0, 1'b0);
    run_sample(4'd3, 0, 1'b0, '0, '0, 0, 1'b0);

    // Coefficients {2,0,0,1}, samples 5,0,0,7 -> 10,0,0,3; one result held 5 cycles
    do_reset();
    cfg_write(2'd0, 8'd2);
    cfg_write(2'd3, 8'd1);
    run_sample(4'd5, 0, 1'b0, '0, '0, 0, 1'b0);
    run_sample(4'd0, 0, 1'b0, '0, '0, 5, 1'b0);
    run_sample(4'd0, 0, 1'b0, '0, '0, 0, 1'b0);
    run_sample(4'd7, 0, 1'b0, '0, '0, 0, 1'b0);

    // Coefficient write during WAIT is dropped
    run_sample(4'd4, 1, 1'b0, '0, '0, 0, 1'b1);
    run_sample(4'd6, 0, 1'b0, '0, '0, 0, 1'b0);

    // PE never answers: timeout after 15 WAIT cycles
    pe_mute = 1'b1;
    in_valid = 1'b1; in_data = 4'd11;
    tick();
    in_valid = 1'b0;
    m_shift(4'd11);
    cyc = 1; to_cnt = 0; first_to = 0; saw_ov = 1'b0;
    while (cyc < 40) begin
      if (pe_timeout) begin
        to_cnt++;
        if (first_to == 0) first_to = cyc;
      end
      if (out_valid) saw_ov = 1'b1;
      tick();
      cyc++;
    end
    pe_mute = 1'b0;
    chk("timeout_cycle", 32'(first_to), 32'(2 + TO));
    chk("timeout_pulse_count", 32'(to_cnt), 1);
    chk("timeout_no_out_valid", 32'(saw_ov), 0);
    chk("timeout_back_to_idle", 32'(in_ready), 1);
    run_sample(4'd2, 0, 1'b0, '0, '0, 0, 1'b0);

    // Randomized coefficients, samples, PE delay, out_ready hold, same-cycle writes
    pe_noise = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cfg_write(AW'($urandom), 8'($urandom));
      cfg_write(AW'($urandom), 8'($urandom));
      run_sample(4'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 AW'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
    pe_noise = 1'b0;

    // Reset during WAIT clears everything
    for (int a = 0; a < N; a++) cfg_write(AW'(a), 8'($urandom_range(1, 255)));
    in_valid = 1'b1; in_data = 4'd13;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_outputs", 32'({in_ready, out_valid, pe_rdy, pe_cin, pe_xin, pe_yin, pe_timeout}), 0);
    rst_n = 1'b1;
    tick();
    m_clear();
    chk("midrst_in_ready", 32'(in_ready), 1);
    run_sample(4'd15, 0, 1'b0, '0, '0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
